// File: rtl/data_memory.sv
// rtl/data_memory.sv - word-organised data memory, combinational read, synchronous write
// Async active-low reset clears every word; address low bits and bits above the array are ignored.
module data_memory #(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic [31:0] WD,
    input  logic [31:0] A,
    input  logic        WE,
    output logic [31:0] RD,
    input  logic        rst_n
);

    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];
    logic [IDX_W-1:0] idx;
    logic             unused_addr_bits;

    assign idx = A[IDX_W+1:2];
    // Byte offset and out-of-range high bits select nothing: unaligned reads alias, large addresses wrap.
    assign unused_addr_bits = ^{A[31:IDX_W+2], A[1:0]};

    assign RD = mem_q[idx];

    always_comb begin
        mem_d = mem_q;
        if (WE) begin
            mem_d[idx] = WD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - self-checking bench for data_memory against an array reference model
module tb_data_memory;

    localparam int DEPTH = 64;

    logic        clk;
    logic        rst_n;
    logic [31:0] WD;
    logic [31:0] A;
    logic        WE;
    logic [31:0] RD;

    int tests_run;
    int tests_failed;

    logic [31:0] model [DEPTH];

    data_memory #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .WD    (WD),
        .A     (A),
        .WE    (WE),
        .RD    (RD),
        .rst_n (rst_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] model_rd(input logic [31:0] addr);
        return model[(addr / 4) % DEPTH];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    // Drive a write, take one edge, settle 1 time unit after it, mirror into the model.
    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        A  = addr;
        WD = data;
        WE = 1'b1;
        @(posedge clk);
        #1;
        if (rst_n) model[(addr / 4) % DEPTH] = data;
        WE = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [4];
        addrs[0] = 32'd0; addrs[1] = 32'd4; addrs[2] = 32'd12; addrs[3] = 32'd252;
        WE = 1'b1;
        WD = 32'hFFFF_FFFF;
        #2 rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        WE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            A = addrs[i];
            #1;
            tests_run++;
            if (RD !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_rd A=%0d got=%h exp=%h", addrs[i], RD, 32'h0);
            end
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        write_word(32'd6, 32'd8);
        write_word(32'd12, 32'd20);
        A = 32'd4; #1;
        tests_run++;
        if (RD !== 32'd8) begin
            tests_failed++;
            $display("FAIL basic_a4 got=%0d exp=%0d", RD, 8);
        end
        A = 32'd12; #1;
        tests_run++;
        if (RD !== 32'd20) begin
            tests_failed++;
            $display("FAIL basic_a12 got=%0d exp=%0d", RD, 20);
        end
        A = 32'd3; #1;
        tests_run++;
        if (RD !== 32'd0) begin
            tests_failed++;
            $display("FAIL basic_a3 got=%0d exp=%0d", RD, 0);
        end
    endtask

    task automatic test_unaligned();
        for (int i = 4; i < 8; i++) begin
            A = 32'(i);
            #1;
            tests_run++;
            if (RD !== 32'd8) begin
                tests_failed++;
                $display("FAIL unaligned A=%0d got=%0d exp=%0d", i, RD, 8);
            end
        end
    endtask

    task automatic test_overwrite();
        A  = 32'd0;
        WD = 32'd40;
        WE = 1'b1;
        #1;
        tests_run++;
        if (RD !== model_rd(32'd0)) begin
            tests_failed++;
            $display("FAIL ow_before_edge got=%h exp=%h", RD, model_rd(32'd0));
        end
        write_word(32'd0, 32'd40);
        WE = 1'b1;
        WD = 32'd1;
        #1;
        tests_run++;
        if (RD !== 32'd40) begin
            tests_failed++;
            $display("FAIL ow_between got=%0d exp=%0d", RD, 40);
        end
        write_word(32'd0, 32'd1);
        tests_run++;
        if (RD !== 32'd1) begin
            tests_failed++;
            $display("FAIL ow_final got=%0d exp=%0d", RD, 1);
        end
    endtask

    task automatic test_wrap_hold();
        write_word(32'd256, 32'hDEADBEEF);
        A = 32'd0; #1;
        tests_run++;
        if (RD !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL wrap_a0 got=%h exp=%h", RD, 32'hDEADBEEF);
        end
        WE = 1'b0;
        for (int i = 0; i < 6; i++) begin
            WD = $urandom;
            A  = $urandom;
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 4; i++) begin
            A = 32'(i * 4);
            #1;
            tests_run++;
            if (RD !== model_rd(A)) begin
                tests_failed++;
                $display("FAIL hold A=%0d got=%h exp=%h", A, RD, model_rd(A));
            end
        end
    endtask

    task automatic test_async_reset();
        write_word(32'd8, 32'h5555_AAAA);
        A  = 32'd8;
        WD = 32'h1234_5678;
        WE = 1'b1;
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        tests_run++;
        if (RD !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_clear got=%h exp=%h", RD, 32'h0);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (RD !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_no_write got=%h exp=%h", RD, 32'h0);
        end
        #2 rst_n = 1'b1;
        #1;
        tests_run++;
        if (RD !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_release got=%h exp=%h", RD, 32'h0);
        end
        write_word(32'd8, 32'h1234_5678);
        tests_run++;
        if (RD !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL async_resume got=%h exp=%h", RD, 32'h1234_5678);
        end
    endtask

    task automatic test_random();
        logic [31:0] ra, rd_addr;
        for (int n = 0; n < 300; n++) begin
            ra = $urandom;
            if (n % 3 == 0) ra = ra & 32'h0000_00FF;
            A  = ra;
            WD = $urandom;
            WE = ($urandom_range(0, 1) == 1);
            #1;
            tests_run++;
            if (RD !== model_rd(ra)) begin
                tests_failed++;
                $display("FAIL rand_pre n=%0d A=%h got=%h exp=%h", n, ra, RD, model_rd(ra));
            end
            @(posedge clk);
            #1;
            if (WE) model[(ra / 4) % DEPTH] = WD;
            rd_addr = $urandom;
            A = rd_addr;
            #1;
            tests_run++;
            if (RD !== model_rd(rd_addr)) begin
                tests_failed++;
                $display("FAIL rand_post n=%0d A=%h got=%h exp=%h", n, rd_addr, RD, model_rd(rd_addr));
            end
        end
        WE = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b1;
        WE    = 1'b0;
        WD    = 32'h0;
        A     = 32'h0;
        test_reset();
        test_basic();
        test_unaligned();
        test_overwrite();
        test_wrap_hold();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
